// File: rtl/reg_bus_arb_tmo_if.sv
// Reg Bus bundle between NI initiators, the arbiter and one shared target.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface reg_bus_arb_tmo_if #(
  parameter int NI  = 4,
  parameter int AW  = 26,
  parameter int DW  = 32,
  parameter int BEW = 4
);
  logic [NI-1:0]     in_reg_cs;
  logic [NI*AW-1:0]  in_reg_addr;
  logic [NI*DW-1:0]  in_reg_wdata;
  logic [NI-1:0]     in_reg_wr;
  logic [NI*BEW-1:0] in_reg_be;
  logic [NI-1:0]     in_reg_ack;
  logic [NI-1:0]     in_reg_timeout;
  logic [DW-1:0]     in_reg_rdata;

  logic              out_reg_cs;
  logic [AW-1:0]     out_reg_addr;
  logic [DW-1:0]     out_reg_wdata;
  logic              out_reg_wr;
  logic [BEW-1:0]    out_reg_be;
  logic [DW-1:0]     out_reg_rdata;
  logic              out_reg_ack;

  modport slave (
    input  in_reg_cs, in_reg_addr, in_reg_wdata, in_reg_wr, in_reg_be,
    input  out_reg_rdata, out_reg_ack,
    output in_reg_ack, in_reg_timeout, in_reg_rdata,
    output out_reg_cs, out_reg_addr, out_reg_wdata, out_reg_wr, out_reg_be
  );

  modport master (
    output in_reg_cs, in_reg_addr, in_reg_wdata, in_reg_wr, in_reg_be,
    output out_reg_rdata, out_reg_ack,
    input  in_reg_ack, in_reg_timeout, in_reg_rdata,
    input  out_reg_cs, out_reg_addr, out_reg_wdata, out_reg_wr, out_reg_be
  );
endinterface

// File: rtl/reg_bus_arb_tmo.sv
// NI-initiator round-robin Reg Bus arbiter with a run-time programmable access timeout.
// Defining REG_BUS_ARB_ERR_STAT_EN adds timeout statistics (err_cnt, err_last_id, err_clr).
module reg_bus_arb_tmo #(
  parameter int NI  = 4,
  parameter int AW  = 26,
  parameter int DW  = 32,
  parameter int BEW = 4,
  parameter int TW  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TW-1:0]         cfg_tmo_limit,
`ifdef REG_BUS_ARB_ERR_STAT_EN
  input  logic                  err_clr,
  output logic [7:0]            err_cnt,
  output logic [$clog2(NI)-1:0] err_last_id,
`endif
  reg_bus_arb_tmo_if.slave      bus
);
  localparam int GW = $clog2(NI);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  grant_q, last_grant_q, grant_sel, cand;
  logic [TW-1:0]  timer_q;
  logic           req_any, tmo_hit, tmo_event;
  logic [NI-1:0]  ack_q, tmo_q;
  logic [DW-1:0]  rdata_q;
  logic           cs_q, wr_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [BEW-1:0] be_q;

  assign req_any   = |bus.in_reg_cs;
  assign tmo_hit   = (cfg_tmo_limit != '0) && (timer_q == cfg_tmo_limit - TW'(1));
  assign tmo_event = (state_q == ACCESS) && !bus.out_reg_ack && tmo_hit;

  // Scan downwards so the requester closest after last_grant is the one left standing.
  always_comb begin
    grant_sel = last_grant_q;
    cand      = '0;
    for (int k = NI; k >= 1; k--) begin
      cand = GW'((int'(last_grant_q) + k) % NI);
      if (bus.in_reg_cs[cand]) grant_sel = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = ACCESS;
      ACCESS:  if (bus.out_reg_ack || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Target ack takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q      <= '0;
      last_grant_q <= GW'(NI - 1);
      timer_q      <= '0;
      ack_q        <= '0;
      tmo_q        <= '0;
      rdata_q      <= '0;
      cs_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      be_q         <= '0;
    end else begin
      ack_q <= '0;
      tmo_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            grant_q <= grant_sel;
            addr_q  <= bus.in_reg_addr[int'(grant_sel)*AW +: AW];
            wdata_q <= bus.in_reg_wdata[int'(grant_sel)*DW +: DW];
            be_q    <= bus.in_reg_be[int'(grant_sel)*BEW +: BEW];
            wr_q    <= bus.in_reg_wr[grant_sel];
            cs_q    <= 1'b1;
            timer_q <= '0;
          end
        end
        ACCESS: begin
          if (timer_q != '1) timer_q <= timer_q + TW'(1);
          if (bus.out_reg_ack) begin
            rdata_q        <= bus.out_reg_rdata;
            ack_q[grant_q] <= 1'b1;
            cs_q           <= 1'b0;
          end else if (tmo_event) begin
            rdata_q        <= '0;
            ack_q[grant_q] <= 1'b1;
            tmo_q[grant_q] <= 1'b1;
            cs_q           <= 1'b0;
          end
        end
        DONE:    last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

`ifdef REG_BUS_ARB_ERR_STAT_EN
  // Clear beats a coincident timeout so software never loses a clear request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt     <= '0;
      err_last_id <= '0;
    end else if (err_clr) begin
      err_cnt     <= '0;
      err_last_id <= '0;
    end else if (tmo_event) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      err_last_id <= grant_q;
    end
  end
`endif

  assign bus.in_reg_ack     = ack_q;
  assign bus.in_reg_timeout = tmo_q;
  assign bus.in_reg_rdata   = rdata_q;
  assign bus.out_reg_cs     = cs_q;
  assign bus.out_reg_addr   = addr_q;
  assign bus.out_reg_wdata  = wdata_q;
  assign bus.out_reg_wr     = wr_q;
  assign bus.out_reg_be     = be_q;
endmodule
